muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the EX-stage multiply/divide resources. It launches the pipelined multiplier and the iterative divider for MULT/MULTU/DIV/DIVU and holds the pipeline with a stall request until the result is ready. It owns the architectural HI/LO registers and also executes MTHI/MTLO. It sits inside EX between the decoded-instruction fields and the `mul`/`div` units; its stall request feeds the central stall controller.

## Interface
- MUL_LAT, 2, multiplier latency: cycles from operands on `mul_ina`/`mul_inb` to a valid `mul_result`; legal range 1..15.

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; aborts any operation in flight
- ex_hold  in  1  EX held by another stall source; the instruction stays in EX
- op_valid  in  1  EX holds a valid muldiv-class instruction
- op  in  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; other codes are no-ops
- src1, src2  in  32  rs and rt values; held stable by the pipeline while `stall_req`=1
- stall_req  out  1  combinational request to stop IF..EX
- done  out  1  one-cycle pulse when HI/LO take a MULT/DIV result
- hi, lo  out  32  architectural HI/LO registers
- mul_signed  out  1  signed multiply select
- mul_ina, mul_inb  out  32  multiplier operands
- mul_result  in  64  {hi, lo} product
- div_start, div_signed, div_annul  out  1  divider controls
- div_opdata1, div_opdata2  out  32  dividend and divisor
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid

## Operation
- States: IDLE, MUL, DIV, DONE. Reset values: state=IDLE, hi=lo=0, counter=0. All outputs are 0 except `mul_ina`/`mul_inb`/`div_opdata*`, which follow `src*`.
- Operand outputs: `mul_ina`=`src1`, `mul_inb`=`src2`, `div_opdata1`=`src1`, `div_opdata2`=`src2` at all times.
- Signed selects: `mul_signed`=(op==MULT) and `div_signed`=(op==DIV), decoded from the current `op`.
- A launch occurs in IDLE when `op_valid`=1 and `flush`=0. Behaviour by op:
  - MULT/MULTU: load counter=MUL_LAT-1; go to MUL.
  - DIV/DIVU with `src2`≠0: `div_start`=1; go to DIV.
  - DIV/DIVU with `src2`=0: no divider start and no stall. Next edge: hi=`src1`, lo=32'hFFFF_FFFF, `done` pulses; go to DONE.
  - MTHI/MTLO: next edge writes hi or lo from `src1`; no stall; remain in IDLE.
- MUL state:
  - counter≠0: decrement.
  - counter=0: hi=`mul_result`[63:32], lo=`mul_result`[31:0], `done`=1; go to DONE.
- DIV state:
  - `div_start`=1 until `div_ready`=1.
  - On `div_ready`: hi=`div_result`[63:32] (remainder), lo=`div_result`[31:0] (quotient), `done`=1; go to DONE.
- DONE state:
  - `stall_req`=0 and `op_valid` is ignored, so the same instruction is never relaunched.
  - Stay while `ex_hold`=1; return to IDLE when `ex_hold`=0.
- `stall_req` = (IDLE & `op_valid` & `!flush` & op∈{MULT,MULTU} or (op∈{DIV,DIVU} & `src2`≠0)) | MUL | DIV.
- Flush:
  - In MUL or DIV: `div_annul`=1 for that cycle (DIV only); go to IDLE; HI/LO unchanged; no `done`.
  - In IDLE: suppresses the launch, including MTHI/MTLO.
  - In DONE: go to IDLE; HI/LO keep the already-committed result.
- Reset mid-operation: immediate return to the reset values; the divider sees `div_start`=0.

## Timing
- MULT: stall_req high for MUL_LAT+1 cycles (T0..T0+MUL_LAT). hi/lo are updated and `done` is high at T0+MUL_LAT+1, in the DONE cycle.
- DIV: stall_req high from T0 through the `div_ready` cycle. hi/lo are valid the cycle after `div_ready`.
- Divide by zero, MTHI, MTLO: zero stall cycles; the result is visible the cycle after launch.
- `done` is registered and lasts exactly one cycle.
- A back-to-back muldiv instruction can launch in the first IDLE cycle after DONE.

## Test plan
- Reset: assert `resetn`=0 during MUL, then release. Expect state IDLE, hi=lo=0, stall_req=0, and no `done`.
- MULT with src1=32'hFFFF_FFFE (-2), src2=3, MUL_LAT=2. Expect stall_req for 3 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, and one `done` pulse. MULTU with the same operands gives hi=2, lo=32'hFFFF_FFFA.
- DIV with src1=-7, src2=2 and a divider model that is ready after 33 cycles. Expect stall_req for 34 cycles, then lo=-3, hi=-1. DIVU 7/2 gives lo=3, hi=1.
- DIVU with src2=0, src1=5. Expect no stall and no div_start; next cycle hi=5, lo=32'hFFFF_FFFF.
- Flush at cycle 10 of a DIV. Expect div_annul for one cycle, state IDLE, hi/lo unchanged, and no `done`.
- MULT completes while ex_hold=1 for 3 cycles. Expect DONE held, no relaunch, and exactly one `done` pulse. MTHI with src1=32'h1234 on the next IDLE cycle gives hi=32'h1234.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the multiply/divide resources.
//
// Purpose
//   Launches the pipelined multiplier (MULT/MULTU) and the iterative divider
//   (DIV/DIVU), requests a pipeline stall until the result is ready, and owns
//   the architectural HI/LO registers. Also executes MTHI/MTLO. A divide by
//   zero is resolved locally (hi=dividend, lo=all ones) without using the divider.
//
// Parameters
//   MUL_LAT      multiplier latency in cycles, legal range 1..15
//
// Ports
//   clk, resetn  clock, asynchronous active-low reset
//   flush        aborts any operation in flight, suppresses a launch
//   ex_hold      EX held by another stall source (keeps DONE)
//   op_valid     EX holds a valid muldiv-class instruction
//   op           1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO, others no-op
//   src1, src2   rs / rt operand values
//   stall_req    combinational stall request to the stall controller
//   done         one-cycle pulse when HI/LO take a MULT/DIV result
//   hi, lo       architectural HI/LO registers
//   mul_*        multiplier operands, signed select and product
//   div_*        divider controls, operands, result and ready
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Counter starts at MUL_LAT-1 so the product is sampled MUL_LAT cycles
    // after the operands were first presented (launch cycle included).
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_d;
    logic [31:0] r_hi;
    logic [31:0] w_hi_d;
    logic [31:0] r_lo;
    logic [31:0] w_lo_d;
    logic        r_done;
    logic        w_done_d;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_launch;

    assign w_is_mul   = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign w_div_zero = (src2 == 32'd0);
    assign w_launch   = (r_state == S_IDLE) && op_valid && !flush;

    // Operands are pass-through; the pipeline holds src* stable while stalled.
    assign mul_ina     = src1;
    assign mul_inb     = src2;
    assign div_opdata1 = src1;
    assign div_opdata2 = src2;

    // Control outputs are forced low while reset is asserted so that nothing
    // downstream (notably the divider) sees a start during reset.
    assign mul_signed = resetn && (op == OP_MULT);
    assign div_signed = resetn && (op == OP_DIV);

    assign stall_req = resetn && (
                           (w_launch && (w_is_mul || (w_is_div && !w_div_zero))) ||
                           (r_state == S_MUL) || (r_state == S_DIV));

    // div_start drops in the ready cycle and on flush so the divider is never
    // re-armed by the instruction it has just finished or abandoned.
    assign div_start = resetn && (
                           (w_launch && w_is_div && !w_div_zero) ||
                           ((r_state == S_DIV) && !div_ready && !flush));

    assign div_annul = resetn && (r_state == S_DIV) && flush;

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_hi_d    = r_hi;
        w_lo_d    = r_lo;
        w_done_d  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    if (w_is_mul) begin
                        w_cnt_d   = CNT_INIT;
                        w_state_d = S_MUL;
                    end else if (w_is_div) begin
                        if (w_div_zero) begin
                            w_hi_d    = src1;
                            w_lo_d    = 32'hFFFF_FFFF;
                            w_done_d  = 1'b1;
                            w_state_d = S_DONE;
                        end else begin
                            w_state_d = S_DIV;
                        end
                    end else if (op == OP_MTHI) begin
                        w_hi_d = src1;
                    end else if (op == OP_MTLO) begin
                        w_lo_d = src1;
                    end
                end
            end

            S_MUL: begin
                if (flush) begin
                    w_state_d = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_d = r_cnt - 4'd1;
                end else begin
                    w_hi_d    = mul_result[63:32];
                    w_lo_d    = mul_result[31:0];
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end
            end

            S_DIV: begin
                if (flush) begin
                    w_state_d = S_IDLE;
                end else if (div_ready) begin
                    w_hi_d    = div_result[63:32];
                    w_lo_d    = div_result[31:0];
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end
            end

            S_DONE: begin
                // The completed instruction may still sit in EX; never relaunch it.
                if (flush || !ex_hold) begin
                    w_state_d = S_IDLE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_hi    <= w_hi_d;
            r_lo    <= w_lo_d;
            r_done  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed test of muldiv_ctrl with a 2-cycle multiplier
// model and a divider model that becomes ready 33 cycles after its start.
// Expected HI/LO results are queued when an instruction is issued and popped
// by a monitor on every done pulse.
module tb_muldiv_ctrl;

    localparam int unsigned MulLat = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        ex_hold = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic [63:0] div_result;
    logic        div_ready;

    muldiv_ctrl #(.MUL_LAT(MulLat)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_hold(ex_hold),
        .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
        .stall_req(stall_req), .done(done), .hi(hi), .lo(lo),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_annul(div_annul), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_result(div_result), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    // Multiplier model: two pipeline stages.
    logic [63:0] w_prod;
    logic [63:0] r_p1;
    logic [63:0] r_p2;
    always_comb begin
        if (mul_signed)
            w_prod = {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
        else
            w_prod = {32'd0, mul_ina} * {32'd0, mul_inb};
    end
    always @(posedge clk) begin
        r_p1 <= w_prod;
        r_p2 <= r_p1;
    end
    assign mul_result = r_p2;

    // Divider model: ready in the 33rd cycle after the start cycle.
    logic r_dbusy;
    int   r_dcnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dbusy <= 1'b0;
            r_dcnt  <= 0;
        end else if (div_annul) begin
            r_dbusy <= 1'b0;
        end else if (!r_dbusy && div_start) begin
            r_dbusy <= 1'b1;
            r_dcnt  <= 1;
        end else if (r_dbusy) begin
            if (div_ready) r_dbusy <= 1'b0;
            else r_dcnt <= r_dcnt + 1;
        end
    end
    assign div_ready = r_dbusy && (r_dcnt == 33);

    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    always_comb begin
        w_sa = div_opdata1;
        w_sb = div_opdata2;
        if (div_opdata2 == 32'd0)
            div_result = 64'd0;
        else if (div_signed)
            div_result = {32'(w_sa % w_sb), 32'(w_sa / w_sb)};
        else
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end

    // Scoreboard.
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
            end else begin
                check("sb_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, counts stall cycles until release, then
    // retires it from EX at the next edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stalls, input logic exp_start, input string name);
        int   stalls;
        logic start_seen;
        stalls = 0;
        start_seen = 1'b0;
        op = o;
        src1 = a;
        src2 = b;
        op_valid = 1'b1;
        @(negedge clk);
        start_seen = start_seen | div_start;
        while (stall_req && stalls < 200) begin
            stalls++;
            @(negedge clk);
            start_seen = start_seen | div_start;
        end
        if (stall_req) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: stall_req still high after %0d cycles", name, stalls);
        end
        check({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        check({name, "_div_start"}, 64'(start_seen), 64'(exp_start));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;

        // Reset values.
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();

        // MULT / MULTU with -2 and 3.
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 3, 1'b0, "mult");
        tick();
        exp_q.push_back({32'h0000_0002, 32'hFFFF_FFFA});
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, 3, 1'b0, "multu");
        tick();

        // DIV -7/2 and DIVU 7/2.
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 34, 1'b1, "div");
        tick();
        exp_q.push_back({32'd1, 32'd3});
        issue(3'd4, 32'd7, 32'd2, 34, 1'b1, "divu");
        tick();

        // DIVU by zero.
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        issue(3'd4, 32'd5, 32'd0, 0, 1'b0, "divu0");
        tick();

        // Flush in cycle 10 of a DIV.
        n0 = n_done;
        op = 3'd3;
        src1 = 32'd100;
        src2 = 32'd7;
        op_valid = 1'b1;
        repeat (10) tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_annul", 64'(div_annul), 64'd1);
        tick();
        flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("flush_annul_drop", 64'(div_annul), 64'd0);
        check("flush_idle_stall", 64'(stall_req), 64'd0);
        check("flush_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        repeat (40) tick();
        check("flush_no_done", 64'(n_done - n0), 64'd0);

        // MULT completing under ex_hold, then MTHI.
        n0 = n_done;
        exp_q.push_back({32'd0, 32'd42});
        ex_hold = 1'b1;
        op = 3'd1;
        src1 = 32'd7;
        src2 = 32'd6;
        op_valid = 1'b1;
        begin
            int stalls;
            stalls = 0;
            @(negedge clk);
            while (stall_req && stalls < 50) begin
                stalls++;
                @(negedge clk);
            end
            check("hold_mult_stalls", 64'(stalls), 64'd3);
        end
        repeat (2) begin
            tick();
            @(negedge clk);
            check("hold_no_relaunch", 64'(stall_req), 64'd0);
        end
        tick();
        ex_hold = 1'b0;
        @(negedge clk);
        check("hold_release_stall", 64'(stall_req), 64'd0);
        tick();
        op = 3'd5;
        src1 = 32'h1234;
        src2 = 32'd0;
        @(negedge clk);
        check("mthi_stall", 64'(stall_req), 64'd0);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("mthi_hilo", {hi, lo}, {32'h0000_1234, 32'd42});
        check("hold_one_done", 64'(n_done - n0), 64'd1);

        // MTLO.
        issue(3'd6, 32'hCAFE_0001, 32'd0, 0, 1'b0, "mtlo");
        @(negedge clk);
        check("mtlo_hilo", {hi, lo}, {32'h0000_1234, 32'hCAFE_0001});
        tick();

        // Reset during MUL.
        n0 = n_done;
        op = 3'd1;
        src1 = 32'd3;
        src2 = 32'd3;
        op_valid = 1'b1;
        tick();
        resetn = 1'b0;
        op_valid = 1'b0;
        #1;
        check("rstmid_stall", 64'(stall_req), 64'd0);
        check("rstmid_hilo", {hi, lo}, 64'd0);
        check("rstmid_div_start", 64'(div_start), 64'd0);
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        check("rstmid_no_done", 64'(n_done - n0), 64'd0);
        check("rstmid_idle_stall", 64'(stall_req), 64'd0);
        check("rstmid_hilo_after", {hi, lo}, 64'd0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
